// File: rtl/time_ascii_sender_pkg.sv
// Shared constants, state encoding and line-length helper for the time
// report serialiser.
package time_ascii_sender_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  // "HH:MM:SS" plus CR LF, or LF alone
  function automatic int unsigned line_len(input bit crlf);
    return crlf ? 32'd10 : 32'd9;
  endfunction

endpackage

// File: rtl/time_ascii_sender_bin2ascii2.sv
// Two-digit decimal ASCII conversion of a 6-bit binary value (0..63).
module bin2ascii2
  import time_ascii_sender_pkg::*;
(
  input  logic [5:0] bin,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [5:0] tens_dig;
  logic [5:0] ones_dig;

  always_comb begin
    tens_dig = bin / 6'd10;
    ones_dig = bin % 6'd10;
    tens     = ASCII_0 + {2'b00, tens_dig};
    ones     = ASCII_0 + {2'b00, ones_dig};
  end

endmodule

// File: rtl/time_ascii_sender.sv
// Snapshots hour/minute/second on a report request and pushes the line
// "HH:MM:SS" + terminator into the Tx FIFO, one byte per non-full cycle.
module time_ascii_sender
  import time_ascii_sender_pkg::*;
#(
  parameter logic [7:0] P_SEP  = 8'h3A,
  parameter bit         P_CRLF = 1'b1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTime_En,
  input  logic [4:0] iHour,
  input  logic [5:0] iMin,
  input  logic [5:0] iSec,
  input  logic       iFull,
  output logic       oPush,
  output logic [7:0] oAscii,
  output logic       oBusy,
  output logic       oDrop
);

  localparam int unsigned LINE_LEN = line_len(P_CRLF);
  localparam logic [3:0]  LAST_IDX = 4'(LINE_LEN - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [4:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;
  logic       drop_r;
  logic [7:0] h10, h1, m10, m1, s10, s1;

  bin2ascii2 u_hour (.bin({1'b0, snap_h}), .tens(h10), .ones(h1));
  bin2ascii2 u_min  (.bin(snap_m),         .tens(m10), .ones(m1));
  bin2ascii2 u_sec  (.bin(snap_s),         .tens(s10), .ones(s1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (iTime_En) state_nxt = ST_SEND;
      ST_SEND: if (!iFull && (idx == LAST_IDX)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oPush  = 1'b0;
    oAscii = '0;
    oBusy  = (state == ST_SEND);
    if (state == ST_SEND) begin
      oPush = !iFull;
      case (idx)
        4'd0:    oAscii = h10;
        4'd1:    oAscii = h1;
        4'd2:    oAscii = P_SEP;
        4'd3:    oAscii = m10;
        4'd4:    oAscii = m1;
        4'd5:    oAscii = P_SEP;
        4'd6:    oAscii = s10;
        4'd7:    oAscii = s1;
        4'd8:    oAscii = P_CRLF ? ASCII_CR : ASCII_LF;
        default: oAscii = ASCII_LF;
      endcase
    end
  end

  // Requests arriving while a line is in flight are rejected, never queued
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      idx    <= '0;
      snap_h <= '0;
      snap_m <= '0;
      snap_s <= '0;
      drop_r <= 1'b0;
    end else begin
      drop_r <= (state == ST_SEND) && iTime_En;
      if ((state == ST_IDLE) && iTime_En) begin
        idx    <= '0;
        snap_h <= iHour;
        snap_m <= iMin;
        snap_s <= iSec;
      end else if (oPush) begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign oDrop = drop_r;

endmodule

// File: tb/tb_time_ascii_sender.sv
// Directed bench for time_ascii_sender: vector table of lines plus
// backpressure, drop, terminator-variant and mid-line reset sequences.
module tb_time_ascii_sender;

  typedef struct {
    logic [4:0]        hour;
    logic [5:0]        min;
    logic [5:0]        sec;
    int                len;
    logic [0:9][7:0]   bytes;
  } line_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       full = 1'b0;
  logic       push0, busy0, drop0;
  logic       push1, busy1, drop1;
  logic [7:0] ascii0, ascii1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_ascii_sender #(.P_SEP(8'h3A), .P_CRLF(1'b1)) dut (
    .iClk(clk), .iRst(rst_n), .iTime_En(en0), .iHour(hour), .iMin(min),
    .iSec(sec), .iFull(full), .oPush(push0), .oAscii(ascii0),
    .oBusy(busy0), .oDrop(drop0)
  );

  time_ascii_sender #(.P_SEP(8'h3A), .P_CRLF(1'b0)) dut_lf (
    .iClk(clk), .iRst(rst_n), .iTime_En(en1), .iHour(hour), .iMin(min),
    .iSec(sec), .iFull(full), .oPush(push1), .oAscii(ascii1),
    .oBusy(busy1), .oDrop(drop1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic line_vec_t mk(input logic [4:0] h, input logic [5:0] m,
                                   input logic [5:0] s, input int len,
                                   input logic [0:9][7:0] b);
    line_vec_t v;
    v.hour = h; v.min = m; v.sec = s; v.len = len; v.bytes = b;
    return v;
  endfunction

  // Request a line and observe a fixed window; fs/fl = stall start cycle/length,
  // mid_change alters the time inputs mid-line, req_last re-requests on the final push.
  task automatic run_line(input bit sel, input line_vec_t v, input int fs, input int fl,
                          input bit mid_change, input bit req_last, input string nm);
    int k = 0;
    int busy_n = 0;
    int drops = 0;
    logic p, b, d;
    logic [7:0] a;
    @(negedge clk);
    hour = v.hour; min = v.min; sec = v.sec; full = 1'b0;
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      full = (fl > 0) && (cyc >= fs) && (cyc < fs + fl);
      if (mid_change && cyc == 2) begin
        hour = 5'd22; min = 6'd44; sec = 6'd11;
      end
      if (req_last && cyc == v.len - 1 + fl) begin
        if (sel) en1 = 1'b1; else en0 = 1'b1;
      end
      #1;
      p = sel ? push1 : push0;
      a = sel ? ascii1 : ascii0;
      b = sel ? busy1 : busy0;
      d = sel ? drop1 : drop0;
      if (b) begin
        busy_n++;
        if (k < v.len) chk({nm, " byte"}, 32'(a), 32'(v.bytes[k]));
        else chk({nm, " busy past line end"}, 32'(b), 32'd0);
        chk({nm, " push"}, 32'(p), 32'(!full));
        if (p) k++;
      end else begin
        chk({nm, " idle push"}, 32'(p), 32'd0);
        chk({nm, " idle ascii"}, 32'(a), 32'd0);
      end
      if (d) drops++;
      @(negedge clk);
      en0 = 1'b0; en1 = 1'b0;
    end
    full = 1'b0;
    chk({nm, " push count"}, 32'(k), 32'(v.len));
    chk({nm, " busy cycles"}, 32'(busy_n), 32'(v.len + fl));
    chk({nm, " drop pulses"}, 32'(drops), req_last ? 32'd1 : 32'd0);
  endtask

  line_vec_t vecs[4];
  line_vec_t vec_lf;

  initial begin
    vecs[0] = mk(5'd13, 6'd5,  6'd59, 10,
                 {8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A});
    vecs[1] = mk(5'd0,  6'd0,  6'd0,  10,
                 {8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A});
    vecs[2] = mk(5'd31, 6'd63, 6'd63, 10,
                 {8'h33, 8'h31, 8'h3A, 8'h36, 8'h33, 8'h3A, 8'h36, 8'h33, 8'h0D, 8'h0A});
    vecs[3] = mk(5'd9,  6'd10, 6'd42, 10,
                 {8'h30, 8'h39, 8'h3A, 8'h31, 8'h30, 8'h3A, 8'h34, 8'h32, 8'h0D, 8'h0A});
    vec_lf  = mk(5'd13, 6'd5,  6'd59, 9,
                 {8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h0A, 8'h00});

    #1;
    chk("reset push",  32'(push0),  32'd0);
    chk("reset ascii", 32'(ascii0), 32'd0);
    chk("reset busy",  32'(busy0),  32'd0);
    chk("reset drop",  32'(drop0),  32'd0);
    chk("reset busy lf", 32'(busy1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle after reset push", 32'(push0), 32'd0);
      chk("idle after reset busy", 32'(busy0), 32'd0);
    end

    for (int i = 0; i < 4; i++) run_line(1'b0, vecs[i], 0, 0, 1'b0, 1'b0, "line");

    run_line(1'b0, vecs[0], 3, 3, 1'b0, 1'b0, "backpressure");
    run_line(1'b0, vecs[0], 0, 0, 1'b1, 1'b1, "snapshot_drop");
    run_line(1'b1, vec_lf,  0, 0, 1'b0, 1'b0, "lf_only");

    // Reset asserted after the 4th push of a line
    @(negedge clk);
    hour = 5'd13; min = 6'd5; sec = 6'd59; en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      chk("pre-reset push", 32'(push0), 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midreset push",  32'(push0),  32'd0);
    chk("midreset busy",  32'(busy0),  32'd0);
    chk("midreset ascii", 32'(ascii0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset busy", 32'(busy0), 32'd0);
    chk("post-reset push", 32'(push0), 32'd0);
    run_line(1'b0, vecs[3], 0, 0, 1'b0, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
